// File: rtl/dmem_cache_responder.sv
// Data-memory responder: direct-mapped write-through read cache over word memory.
// Optional DMEM_STATS_EN adds saturating hitCount/missCount output ports.
module dmem_cache_responder #(
    parameter int LINES     = 16,
    parameter int MEM_WORDS = 256,
    parameter int MISS_LAT  = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        memWrite,
    input  logic        memRead,
    output logic [31:0] ReadData,
    output logic        memError
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`endif
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;
    localparam int MW = $clog2(MEM_WORDS);
    localparam int CW = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [29:0]      lat_q, lat_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic [TW-1:0] tag_q  [LINES];
    logic [31:0]   data_q [LINES];
    logic [31:0]   mem_q  [MEM_WORDS];

    logic [29:0]   word;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [MW-1:0] maddr;
    logic [IW-1:0] lat_idx;
    logic [TW-1:0] lat_tag;
    logic [MW-1:0] lat_maddr;

    logic hit;
    logic rd_req;
    logic is_idle;
    logic fill_en;
    logic wr_en;
    logic line_wr;
    logic unused_addr;

    assign word        = Address[31:2];
    assign idx         = word[IW-1:0];
    assign tag         = word[29:IW];
    assign maddr       = word[MW-1:0];
    assign lat_idx     = lat_q[IW-1:0];
    assign lat_tag     = lat_q[29:IW];
    assign lat_maddr   = lat_q[MW-1:0];
    assign unused_addr = ^Address[1:0];

    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign rd_req  = memRead && !memWrite;
    assign is_idle = (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        valid_d = valid_q;
        fill_en = 1'b0;
        wr_en   = 1'b0;
        line_wr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (memWrite) begin
                    wr_en   = 1'b1;
                    line_wr = hit;
                end else if (memRead && !hit) begin
                    lat_d   = word;
                    cnt_d   = CW'(MISS_LAT - 1);
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    fill_en          = 1'b1;
                    valid_d[lat_idx] = 1'b1;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // reset abandons any fill and blocks stores in the same cycle
        if (Rst) begin
            fill_en = 1'b0;
            wr_en   = 1'b0;
            line_wr = 1'b0;
        end
    end

    always_comb begin
        memError = 1'b0;
        ReadData = '0;
        if (!Rst) begin
            memError = !is_idle || (rd_req && !hit);
            if (is_idle && rd_req && hit) begin
                ReadData = data_q[idx];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (fill_en) begin
            tag_q[lat_idx]  <= lat_tag;
            data_q[lat_idx] <= mem_q[lat_maddr];
        end else if (line_wr) begin
            data_q[idx] <= WriteData;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[maddr] <= WriteData;
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (is_idle && rd_req && hit && hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (is_idle && state_d == S_FILL && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_cache_responder.sv
// Randomized bench for dmem_cache_responder against a line/memory reference model.
// Directed scenarios first, then random traffic; stats ports used when DMEM_STATS_EN.
module tb_dmem_cache_responder;

    localparam int LINES     = 16;
    localparam int MEM_WORDS = 256;
    localparam int MISS_LAT  = 4;

    logic        Clk;
    logic        Rst;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] ReadData;
    logic        memError;
`ifdef DMEM_STATS_EN
    logic [31:0] hitCount;
    logic [31:0] missCount;
`endif

    dmem_cache_responder #(
        .LINES(LINES),
        .MEM_WORDS(MEM_WORDS),
        .MISS_LAT(MISS_LAT)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Address(Address),
        .WriteData(WriteData),
        .memWrite(memWrite),
        .memRead(memRead),
        .ReadData(ReadData),
        .memError(memError)
`ifdef DMEM_STATS_EN
        ,
        .hitCount(hitCount),
        .missCount(missCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec;
    int n_err;

    // reference model: lines remember the full word they hold
    logic [31:0] mmem  [MEM_WORDS];
    bit          cval  [LINES];
    int          cword [LINES];
    logic [31:0] cdat  [LINES];
    int          fill_left;
    int          pend;

    logic        last_err;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic w,
                        input logic rd);
        int          wi;
        int          li;
        bit          hitm;
        logic        e_err;
        logic [31:0] e_rd;
        @(negedge Clk);
        Rst       = r;
        Address   = a;
        WriteData = d;
        memWrite  = w;
        memRead   = rd;
        wi   = int'(a[31:2]);
        li   = wi % LINES;
        hitm = cval[li] && cword[li] == wi;
        e_err = 1'b0;
        e_rd  = '0;
        if (!r) begin
            if (fill_left > 0) begin
                e_err = 1'b1;
            end else if (rd && !w) begin
                if (hitm) e_rd = cdat[li];
                else      e_err = 1'b1;
            end
        end
        #1;
        last_err = memError;
        last_rd  = ReadData;
        check("memError", {31'd0, memError}, {31'd0, e_err});
        check("ReadData", ReadData, e_rd);
        @(posedge Clk);
        if (r) begin
            for (int i = 0; i < LINES; i++) cval[i] = 0;
            fill_left = 0;
        end else if (fill_left > 0) begin
            fill_left--;
            if (fill_left == 0) begin
                cval[pend % LINES]  = 1;
                cword[pend % LINES] = pend;
                cdat[pend % LINES]  = mmem[pend % MEM_WORDS];
            end
        end else if (w) begin
            mmem[wi % MEM_WORDS] = d;
            if (hitm) cdat[li] = d;
        end else if (rd && !hitm) begin
            fill_left = MISS_LAT;
            pend      = wi;
        end
    endtask

    task automatic read_wait(input logic [31:0] a, output int stalls);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, a, 32'd0, 1'b0, 1'b1);
            if (!last_err) break;
            stalls++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          st;
        logic [31:0] old9;
        logic [31:0] v;
        n_vec = 0;
        n_err = 0;
        fill_left = 0;
        pend = 0;
        Rst = 1'b1;
        Address = '0;
        WriteData = '0;
        memWrite = 1'b0;
        memRead = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            cval[i] = 0;
            cword[i] = 0;
            cdat[i] = '0;
        end
        for (int i = 0; i < MEM_WORDS; i++) begin
            v = $urandom;
            mmem[i] = v;
            dut.mem_q[i] = v;
        end
        mmem[5] = 32'hDEADBEEF;
        dut.mem_q[5] = 32'hDEADBEEF;

        step(1'b1, 32'h14, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'h14, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'd0, 1'b0, 1'b0);

        read_wait(32'h14, st);
        check("cold_stall", st, MISS_LAT + 1);
        check("cold_data", last_rd, 32'hDEADBEEF);

        step(1'b0, 32'h14, 32'd0, 1'b0, 1'b1);
        check("hit_err", {31'd0, last_err}, 32'd0);
        check("hit_data", last_rd, 32'hDEADBEEF);
`ifdef DMEM_STATS_EN
        check("missCount", missCount, 32'd1);
        check("hitCount", hitCount, 32'd2);
`endif

        step(1'b0, 32'h14, 32'h12345678, 1'b1, 1'b0);
        check("wt_err", {31'd0, last_err}, 32'd0);
        step(1'b0, 32'h14, 32'd0, 1'b0, 1'b1);
        check("wt_data", last_rd, 32'h12345678);
        check("wt_mem5", dut.mem_q[5], 32'h12345678);

        step(1'b0, 32'h54, 32'hA5A5A5A5, 1'b1, 1'b0);
        check("noalloc_err", {31'd0, last_err}, 32'd0);
        step(1'b0, 32'h14, 32'd0, 1'b0, 1'b1);
        check("conflict_hit", last_rd, 32'h12345678);
        read_wait(32'h54, st);
        check("evict_stall", st, MISS_LAT + 1);
        check("evict_data", last_rd, 32'hA5A5A5A5);

        old9 = mmem[9];
        step(1'b0, 32'h20, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h20, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < MISS_LAT - 1; i++) begin
            step(1'b0, 32'h24, 32'hCAFEF00D, 1'b1, 1'b0);
            check("midfill_err", {31'd0, last_err}, 32'd1);
        end
        check("midfill_nowrite", dut.mem_q[9], old9);
        step(1'b0, 32'h20, 32'd0, 1'b0, 1'b1);
        check("midfill_line", {31'd0, last_err}, 32'd0);

        step(1'b0, 32'h40, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h40, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'h40, 32'd0, 1'b0, 1'b1);
        check("rst_err", {31'd0, last_err}, 32'd0);
        check("rst_data", last_rd, 32'd0);
        read_wait(32'h40, st);
        check("rst_refill", st, MISS_LAT + 1);

        for (int n = 0; n < 600; n++) begin
            int          wsel;
            logic [31:0] a;
            wsel = $urandom_range(0, 5) + LINES * $urandom_range(0, 2)
                 + MEM_WORDS * $urandom_range(0, 1);
            a = {wsel[29:0], 2'b00} | ($urandom & 32'h3);
            step($urandom_range(0, 99) < 2, a, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_cache_responder.md
# dmem_cache_responder

Responder for the CPU's data-memory port: it answers the MEM-stage read/write requests and drives `memError`, which the pipeline register controller uses to stall. Reads are served by a direct-mapped, one-word-per-line, write-through cache in front of an internal word-addressed main memory. A read miss holds `memError` high while the line fills over a fixed number of cycles. Write hits and write misses complete without stalling.

## Interface
- `LINES`, 16, number of cache lines; power of two, at least 2.
- `MEM_WORDS`, 256, main-memory depth in 32-bit words; power of two.
- `MISS_LAT`, 4, fill latency in cycles; at least 1.

- `Clk` in 1: sole clock, rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `Address` in 32: byte address. Bits [1:0] are ignored.
- `WriteData` in 32: store data.
- `memWrite` in 1: store request.
- `memRead` in 1: load request.
- `ReadData` out 32: load data. Combinational; valid in the same cycle as a read hit.
- `memError` out 1: busy/stall. Combinational.

## Operation
- Address decode, with IW = log2(`LINES`):
  - word = `Address[31:2]`.
  - index = word[IW-1:0].
  - tag = word[29:IW].
  - main-memory address = word modulo `MEM_WORDS` (wraps silently).
- Storage:
  - `LINES` entries of {valid, tag, data}.
  - Main memory of `MEM_WORDS` x 32. It is not cleared by reset; the bench preloads it hierarchically.
- hit = valid[index] && tag[index] == tag.
- FSM states: IDLE, FILL.
  - IDLE with read miss (`memRead` && !`memWrite` && !hit):
    - latch word address;
    - count = `MISS_LAT`-1;
    - go to FILL.
  - FILL, count != 0: decrement count.
  - FILL, count == 0:
    - line[latched index] = {1, latched tag, mem[latched word]};
    - go to IDLE.
  - Fill completes even if `memRead` drops or `Address` changes mid-fill. The latched address is used.
- Writes are accepted only in IDLE. When `memWrite` is high:
  - mem[word] is written on the clock edge.
  - If hit, the cache line data is also written (write-through).
  - Write miss: no allocate, no stall.
- `memRead` and `memWrite` high together: the write wins and the read is ignored (no miss, `ReadData`=0).
- `memError` = (state==FILL) || (state==IDLE && `memRead` && !`memWrite` && !hit). A write presented during FILL is held off by `memError`=1 and is not performed.
- `ReadData` = line data when state==IDLE && `memRead` && !`memWrite` && hit; otherwise 0.

## Timing
- Read hit: zero-latency, combinational. `memError`=0 in the request cycle.
- Read miss:
  - `memError`=1 in the request cycle (cycle 0) and for the `MISS_LAT` FILL cycles.
  - The line is written at the end of cycle `MISS_LAT`.
  - In cycle `MISS_LAT`+1 the held request hits: `memError`=0 and data is valid.
  - Total stall is `MISS_LAT`+1 cycles.
- Write: committed on the edge ending the request cycle; `memError`=0 in IDLE.
- A read of the just-written address in the next cycle returns the new data, provided the line was valid with a matching tag, or is filled afterwards from updated memory.
- Reset:
  - While `Rst`=1, outputs are forced: `memError`=0, `ReadData`=0.
  - At the edge: all valid bits cleared, state=IDLE, count=0, statistic counters=0.
  - Reset mid-FILL abandons the fill; no line is written.
- Consecutive misses to different indexes are serialized. Each pays the full `MISS_LAT`+1.

## Configuration
- `DMEM_STATS_EN`
  - Defined:
    - Adds output ports `hitCount` (out 32) and `missCount` (out 32). Both are reset to 0.
    - `hitCount` increments on each IDLE cycle with a read hit.
    - `missCount` increments on each IDLE→FILL transition.
    - Both saturate at 32'hFFFFFFFF.
    - A retried hit after a fill also counts as a hit.
  - Undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Cold read miss:
  - Setup: reset, then mem[5]=32'hDEADBEEF; hold `Address`=32'h14, `memRead`=1.
  - Response: `memError`=1 for 5 cycles (`MISS_LAT`=4). In cycle 6, `memError`=0 and `ReadData`=32'hDEADBEEF.
- Read hit:
  - Stimulus: repeat the read of 32'h14.
  - Response: `memError`=0 immediately, `ReadData`=32'hDEADBEEF.
  - With `DMEM_STATS_EN`: `missCount`=1, `hitCount`=2.
- Write-through on hit:
  - Stimulus: write 32'h12345678 to 32'h14, then read it.
  - Response: no stall, `ReadData`=32'h12345678, mem[5]=32'h12345678.
- Conflict and no-allocate:
  - Stimulus: write 32'hA5A5A5A5 to 32'h54 (index 5, different tag), then read 32'h14, then read 32'h54.
  - Response: the write does not stall, and the read of 32'h14 still hits with 32'h12345678. The read of 32'h54 misses (5-cycle stall) and returns 32'hA5A5A5A5, evicting line 5.
- Mid-fill behaviour:
  - Stimulus: start a miss on 32'h20; at fill cycle 2 drop `memRead` and assert `memWrite` to 32'h24.
  - Response: `memError` stays 1 through FILL and the write is not performed. The line for 32'h20 is valid afterwards.
- Reset during FILL:
  - Stimulus: assert `Rst` in fill cycle 2.
  - Response: `memError`=0 during reset, and a subsequent read of the same address misses again (full stall).
